stream_demux: RTL and testbench

STREAM_DEMUX -- requirements
Module: stream_demux

---
 rtl/stream_demux.sv | 51 +++++
 tb/tb_stream_demux.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/stream_demux.sv
// stream_demux: routes one input stream to N_CH independently drained output channels.
// Targets come from in_sel (addressed) or a wrapping scan pointer; out-of-range beats are dropped and counted.
module stream_demux #(
   parameter int DATA_W = 8,
   parameter int N_CH   = 8,
   parameter int SEL_W  = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   mode,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_W-1:0]      in_data,
   input  logic [SEL_W-1:0]       in_sel,
   output logic [N_CH-1:0]        out_valid,
   input  logic [N_CH-1:0]        out_ready,
   output logic [N_CH*DATA_W-1:0] out_data,
   output logic                   err,
   output logic [7:0]             drop_cnt
);
   localparam logic [SEL_W:0]   N_LIM = (SEL_W+1)'(N_CH);
   localparam logic [SEL_W-1:0] LAST  = SEL_W'(N_CH - 1);
   logic [SEL_W-1:0] ptr, t;
   logic             hit, acc;
   logic [N_CH-1:0]  load;
   always_comb begin
      t = mode ? ptr : in_sel;
      hit = {1'b0, t} < N_LIM;
      in_ready = !hit || !out_valid[t] || out_ready[t];
      acc = in_valid && in_ready;
      load = '0;
      if (acc && hit) load[t] = 1'b1;
   end
   // a load on the same edge as a drain wins, keeping one beat per cycle per channel
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= '0;
         out_data  <= '0;
         ptr       <= '0;
         err       <= 1'b0;
         drop_cnt  <= '0;
      end else begin
         for (int k = 0; k < N_CH; k++)
            if (load[k]) out_data[k*DATA_W +: DATA_W] <= in_data;
         out_valid <= load | (out_valid & ~out_ready);
         if (acc && mode) ptr <= (ptr == LAST) ? '0 : ptr + SEL_W'(1);
         err <= acc && !hit;
         if (acc && !hit && !(&drop_cnt)) drop_cnt <= drop_cnt + 8'd1;
      end
   end
endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux: directed checks of stream_demux, default build plus a 6-channel build for drops.
module tb_stream_demux;
   logic        clk = 1'b0, rst_n = 1'b0, mode = 1'b0, in_valid = 1'b0;
   logic [7:0]  in_data = '0;
   logic [2:0]  in_sel = '0;
   logic        in_ready, err;
   logic [7:0]  out_valid, drop_cnt;
   logic [7:0]  out_ready = '1;
   logic [63:0] out_data;
   logic        mode6 = 1'b0, in_valid6 = 1'b0, in_ready6, err6;
   logic [7:0]  in_data6 = 8'h55, drop6;
   logic [2:0]  in_sel6 = 3'd7;
   logic [5:0]  out_valid6;
   logic [5:0]  out_ready6 = '1;
   logic [47:0] out_data6;
   int          n_chk = 0, n_pass = 0;

   stream_demux dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .err(err), .drop_cnt(drop_cnt)
   );

   stream_demux #(.DATA_W(8), .N_CH(6), .SEL_W(3)) dut6 (
      .clk(clk), .rst_n(rst_n), .mode(mode6), .in_valid(in_valid6), .in_ready(in_ready6),
      .in_data(in_data6), .in_sel(in_sel6), .out_valid(out_valid6), .out_ready(out_ready6),
      .out_data(out_data6), .err(err6), .drop_cnt(drop6)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic v, input logic [2:0] s, input logic [7:0] d);
      in_valid = v;
      in_sel   = s;
      in_data  = d;
      #1;
   endtask

   initial begin
      #2;
      chk("rst_vld", 32'(out_valid), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      chk("rst_drop", 32'(drop_cnt), 32'h0);
      chk("rst_rdy", 32'(in_ready), 32'h1);
      chk("rst_vld6", 32'(out_valid6), 32'h0);
      #11 rst_n = 1'b1;
      tick;
      for (int s = 0; s < 8; s++) begin
         beat(1'b1, 3'(s), 8'(8'hA0 + s));
         chk("sweep_rdy", 32'(in_ready), 32'h1);
         tick;
         chk("sweep_vld", 32'(out_valid), 32'(1 << s));
         chk("sweep_dat", 32'(out_data[s*8 +: 8]), 32'(8'hA0 + s));
      end
      beat(1'b0, 3'd0, 8'h00);
      tick;
      chk("sweep_idle", 32'(out_valid), 32'h0);
      out_ready = 8'hF7;
      beat(1'b1, 3'd3, 8'h11);
      chk("bp_rdy1", 32'(in_ready), 32'h1);
      tick;
      chk("bp_vld1", 32'(out_valid), 32'h08);
      chk("bp_dat1", 32'(out_data[31:24]), 32'h11);
      beat(1'b1, 3'd3, 8'h22);
      chk("bp_rdy2", 32'(in_ready), 32'h0);
      tick;
      chk("bp_hold_vld", 32'(out_valid), 32'h08);
      chk("bp_hold_dat", 32'(out_data[31:24]), 32'h11);
      out_ready = '1;
      #1;
      chk("bp_rdy3", 32'(in_ready), 32'h1);
      tick;
      chk("bp_swap_vld", 32'(out_valid), 32'h08);
      chk("bp_swap_dat", 32'(out_data[31:24]), 32'h22);
      beat(1'b0, 3'd0, 8'h00);
      tick;
      chk("bp_idle", 32'(out_valid), 32'h0);
      in_valid6 = 1'b1;
      #1;
      chk("drop_rdy", 32'(in_ready6), 32'h1);
      tick;
      chk("drop_vld", 32'(out_valid6), 32'h0);
      chk("drop_err", 32'(err6), 32'h1);
      chk("drop_cnt1", 32'(drop6), 32'h1);
      in_valid6 = 1'b0;
      tick;
      chk("drop_err_once", 32'(err6), 32'h0);
      chk("drop_cnt_hold", 32'(drop6), 32'h1);
      in_valid6 = 1'b1;
      repeat (299) tick;
      chk("drop_sat", 32'(drop6), 32'hFF);
      in_valid6 = 1'b0;
      tick;
      chk("drop_sat_hold", 32'(drop6), 32'hFF);
      chk("drop_err_off", 32'(err6), 32'h0);
      mode = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         beat(1'b1, 3'd0, 8'(i));
         tick;
         chk("scan_vld", 32'(out_valid), 32'(1 << ((i - 1) % 8)));
         chk("scan_dat", 32'(out_data[((i - 1) % 8)*8 +: 8]), 32'(i));
      end
      beat(1'b1, 3'd0, 8'h0B);
      tick;
      chk("scan_ptr2", 32'(out_valid), 32'h04);
      beat(1'b0, 3'd0, 8'h00);
      tick;
      mode = 1'b0;
      out_ready = '0;
      beat(1'b1, 3'd2, 8'h2C);
      tick;
      beat(1'b1, 3'd5, 8'h5C);
      tick;
      beat(1'b0, 3'd0, 8'h00);
      chk("mid_full", 32'(out_valid), 32'h24);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_vld", 32'(out_valid), 32'h0);
      chk("mid_rst_dat", 32'(|out_data), 32'h0);
      chk("mid_rst_drop6", 32'(drop6), 32'h0);
      chk("mid_rst_rdy", 32'(in_ready), 32'h1);
      #2 rst_n = 1'b1;
      tick;
      out_ready = '1;
      mode = 1'b1;
      for (int i = 0; i < 3; i++) begin
         beat(1'b1, 3'd0, 8'(8'h30 + i));
         tick;
         chk("ms_scan", 32'(out_valid), 32'(1 << i));
      end
      mode = 1'b0;
      for (int i = 0; i < 2; i++) begin
         beat(1'b1, 3'd6, 8'(8'h36 + i));
         tick;
         chk("ms_addr", 32'(out_valid), 32'h40);
      end
      mode = 1'b1;
      beat(1'b1, 3'd0, 8'h3F);
      tick;
      chk("ms_resume_vld", 32'(out_valid), 32'h08);
      chk("ms_resume_dat", 32'(out_data[31:24]), 32'h3F);
      beat(1'b0, 3'd0, 8'h00);
      tick;
      chk("end_idle", 32'(out_valid), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
